// File: rtl/sprite_renderer.sv
// Sprite blitter and screen clearer driving a pixel-write VGA adapter.
// Sprite pixels leave a two-stage pipeline that covers the synchronous ROM read.
module sprite_renderer #(
  parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120,
  parameter int unsigned SPRITE_W        = 16,
  parameter int unsigned SPRITE_H        = 16,
  parameter logic [2:0]  KEY_COLOUR      = 3'b101
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic [7:0] x_in_i,
  input  logic [6:0] y_in_i,
  output logic [7:0] rom_addr_o,
  input  logic [2:0] rom_data_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       plot_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned NumPix  = SPRITE_W * SPRITE_H;
  localparam logic [7:0]  LastAddr = 8'(NumPix - 1);
  localparam logic [7:0]  LastCol  = 8'(SPRITE_W - 1);
  localparam logic [7:0]  LastX    = X_SCREEN_PIXELS - 8'd1;
  localparam logic [6:0]  LastY    = Y_SCREEN_PIXELS - 7'd1;

  // StFetch issues ROM addresses, StDraw drains the two pipeline stages.
  typedef enum logic [2:0] {StIdle, StFetch, StDraw, StClear, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [7:0] xb_q, xb_d;
  logic [6:0] yb_q, yb_d;
  logic       drain_q, drain_d;
  logic       p1_valid_q, p1_valid_d;
  logic [7:0] p1_col_q, p1_col_d;
  logic [6:0] p1_row_q, p1_row_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [8:0] x_sum;
  logic [7:0] y_sum;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    xb_d       = xb_q;
    yb_d       = yb_q;
    drain_d    = drain_q;
    p1_valid_d = (state_q == StFetch);
    p1_col_d   = col_q;
    p1_row_d   = row_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    x_sum      = {1'b0, xb_q} + {1'b0, p1_col_q};
    y_sum      = {1'b0, yb_q} + {1'b0, p1_row_q};

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          state_d  = StClear;
          x_d      = 8'd0;
          y_d      = 7'd0;
          colour_d = 3'b000;
          plot_d   = 1'b1;
        end else if (start_i) begin
          state_d = StFetch;
          addr_d  = 8'd0;
          col_d   = 8'd0;
          row_d   = 7'd0;
          xb_d    = x_in_i;
          yb_d    = y_in_i;
        end
      end
      StFetch: begin
        if (addr_q == LastAddr) begin
          state_d = StDraw;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 8'd1;
          if (col_q == LastCol) begin
            col_d = 8'd0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      StDraw: begin
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      StClear: begin
        if (x_q == LastX && y_q == LastY) begin
          state_d = StDone;
        end else begin
          plot_d = 1'b1;
          if (x_q == LastX) begin
            x_d = 8'd0;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // rom_data_i this cycle belongs to the address captured in stage 1.
    if (p1_valid_q) begin
      x_d      = x_sum[7:0];
      y_d      = y_sum[6:0];
      colour_d = rom_data_i;
      plot_d   = (rom_data_i != KEY_COLOUR) && (x_sum < {1'b0, X_SCREEN_PIXELS}) &&
                 (y_sum < {1'b0, Y_SCREEN_PIXELS});
    end

    busy_d = (state_d == StFetch) || (state_d == StDraw) || (state_d == StClear);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= 8'd0;
      col_q      <= 8'd0;
      row_q      <= 7'd0;
      xb_q       <= 8'd0;
      yb_q       <= 7'd0;
      drain_q    <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_col_q   <= 8'd0;
      p1_row_q   <= 7'd0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      colour_q   <= 3'b000;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      xb_q       <= xb_d;
      yb_q       <= yb_d;
      drain_q    <= drain_d;
      p1_valid_q <= p1_valid_d;
      p1_col_q   <= p1_col_d;
      p1_row_q   <= p1_row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr_o = addr_q;
  assign x_o        = x_q;
  assign y_o        = y_q;
  assign colour_o   = colour_q;
  assign plot_o     = plot_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: sprite draws, clipping, keying, clear, reset abort.
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x_in = 8'd0;
  logic [6:0] y_in = 7'd0;
  logic [7:0] rom_addr;
  logic [2:0] rom_data = 3'b000;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int passed = 0;
  int total  = 0;
  int rom_mode = 0;

  int n_plot, first_c, last_c, minx, maxx, miny, maxy;
  int coord_bad, addr_bad, odd_x, busy_cnt, done_c, done_cnt, busy_at_done;

  sprite_renderer dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start),
    .clear_i   (clear),
    .x_in_i    (x_in),
    .y_in_i    (y_in),
    .rom_addr_o(rom_addr),
    .rom_data_i(rom_data),
    .x_o       (x),
    .y_o       (y),
    .colour_o  (colour),
    .plot_o    (plot),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_val(input int k);
    case (rom_mode)
      0:       return 3'b010;
      1:       return 3'b001;
      default: return (k % 2 == 0) ? 3'b101 : 3'b100;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  // Launches one operation and gathers statistics until done or max_c cycles.
  task automatic run_op(input bit s, input bit c, input logic [7:0] xb, input logic [6:0] yb,
                        input int max_c, input int pulse_c, input bit hold);
    int k;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ecol;
    n_plot = 0; first_c = -1; last_c = -1; minx = 999; maxx = -1; miny = 999; maxy = -1;
    coord_bad = 0; addr_bad = 0; odd_x = 0; busy_cnt = 0; done_c = -1; done_cnt = 0;
    busy_at_done = 0;
    @(negedge clk);
    start = s; clear = c; x_in = xb; y_in = yb;
    for (int cyc = 1; cyc <= max_c; cyc++) begin
      @(negedge clk);
      if (c) begin
        ex = 8'((cyc - 1) % 160);
        ey = 7'((cyc - 1) / 160);
        ecol = 3'b000;
      end else begin
        k = cyc - 3;
        ex = 8'(int'(xb) + (k % 16));
        ey = 7'(int'(yb) + (k / 16));
        ecol = rom_val(k);
        if (cyc <= 256 && int'(rom_addr) != cyc - 1) addr_bad++;
      end
      if (plot) begin
        n_plot++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (int'(x) < minx) minx = int'(x);
        if (int'(x) > maxx) maxx = int'(x);
        if (int'(y) < miny) miny = int'(y);
        if (int'(y) > maxy) maxy = int'(y);
        if (x[0]) odd_x++;
        if ((!c && cyc < 3) || x !== ex || y !== ey || colour !== ecol) coord_bad++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = cyc;
        if (busy) busy_at_done++;
      end
      if (cyc == pulse_c) start = 1'b1;
      else if (pulse_c > 0 && cyc == pulse_c + 1) start = 1'b0;
      if (cyc == 1 && !hold) begin
        start = 1'b0;
        clear = 1'b0;
      end
      if (done) break;
    end
  endtask

  task automatic test_reset;
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({plot, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {plot, busy, done});
    else passed++;
    total++;
    if ({rom_addr, x, y, colour} !== 26'd0)
      $display("FAIL reset_regs: got %h want 0", {rom_addr, x, y, colour});
    else passed++;
    start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_holds_idle: busy got %b want 0", busy);
    else passed++;
    start = 1'b0;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || plot !== 1'b0) $display("FAIL idle_after_reset: busy/plot got %b%b want 00", busy, plot);
    else passed++;
  endtask

  task automatic test_draw;
    rom_mode = 0;
    run_op(1'b1, 1'b0, 8'd10, 7'd20, 400, 0, 1'b0);
    total++; if (n_plot !== 256) $display("FAIL draw_plots: got %0d want 256", n_plot); else passed++;
    total++; if (first_c !== 3 || last_c !== 258)
      $display("FAIL draw_window: got %0d..%0d want 3..258", first_c, last_c); else passed++;
    total++; if (minx !== 10 || maxx !== 25 || miny !== 20 || maxy !== 35)
      $display("FAIL draw_extent: got x%0d..%0d y%0d..%0d want x10..25 y20..35", minx, maxx, miny, maxy);
    else passed++;
    total++; if (coord_bad !== 0) $display("FAIL draw_pixels: got %0d bad want 0", coord_bad); else passed++;
    total++; if (addr_bad !== 0) $display("FAIL draw_rom_addr: got %0d bad want 0", addr_bad); else passed++;
    total++; if (done_c !== 259 || done_cnt !== 1)
      $display("FAIL draw_done: got cycle %0d count %0d want 259 1", done_c, done_cnt); else passed++;
    total++; if (busy_cnt !== 258 || busy_at_done !== 0)
      $display("FAIL draw_busy: got %0d cycles, %0d at done want 258 0", busy_cnt, busy_at_done);
    else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL draw_return_idle: got done %b busy %b want 0 0", done, busy);
    else passed++;
  endtask

  task automatic test_clip;
    rom_mode = 1;
    run_op(1'b1, 1'b0, 8'd150, 7'd110, 400, 0, 1'b0);
    total++; if (n_plot !== 100) $display("FAIL clip_plots: got %0d want 100", n_plot); else passed++;
    total++; if (minx !== 150 || maxx !== 159 || miny !== 110 || maxy !== 119)
      $display("FAIL clip_extent: got x%0d..%0d y%0d..%0d want x150..159 y110..119", minx, maxx, miny, maxy);
    else passed++;
    total++; if (coord_bad !== 0) $display("FAIL clip_pixels: got %0d bad want 0", coord_bad); else passed++;
    total++; if (done_c !== 259) $display("FAIL clip_done: got %0d want 259", done_c); else passed++;
  endtask

  task automatic test_key;
    rom_mode = 2;
    run_op(1'b1, 1'b0, 8'd0, 7'd0, 400, 0, 1'b0);
    total++; if (n_plot !== 128) $display("FAIL key_plots: got %0d want 128", n_plot); else passed++;
    total++; if (odd_x !== 128) $display("FAIL key_odd_x: got %0d want 128", odd_x); else passed++;
    total++; if (coord_bad !== 0) $display("FAIL key_pixels: got %0d bad want 0", coord_bad); else passed++;
  endtask

  task automatic test_clear;
    rom_mode = 0;
    run_op(1'b1, 1'b1, 8'd33, 7'd44, 19300, 5000, 1'b0);
    total++; if (n_plot !== 19200) $display("FAIL clear_plots: got %0d want 19200", n_plot); else passed++;
    total++; if (first_c !== 1 || last_c !== 19200)
      $display("FAIL clear_window: got %0d..%0d want 1..19200", first_c, last_c); else passed++;
    total++; if (coord_bad !== 0) $display("FAIL clear_pixels: got %0d bad want 0", coord_bad); else passed++;
    total++; if (maxx !== 159 || maxy !== 119) $display("FAIL clear_extent: got %0d,%0d want 159,119", maxx, maxy);
    else passed++;
    total++; if (done_c !== 19201 || done_cnt !== 1)
      $display("FAIL clear_done: got cycle %0d count %0d want 19201 1", done_c, done_cnt); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL clear_idle: busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_midop;
    int bad = 0;
    rom_mode = 0;
    run_op(1'b1, 1'b0, 8'd10, 7'd20, 43, 0, 1'b0);
    total++; if (plot !== 1'b1 || x !== 8'd18 || y !== 7'd22)
      $display("FAIL midop_pixel40: got plot %b (%0d,%0d) want 1 (18,22)", plot, x, y); else passed++;
    #1 rst_ni = 1'b0;
    #1;
    total++; if ({plot, busy, done} !== 3'b000 || rom_addr !== 8'd0)
      $display("FAIL midop_async: got flags %b addr %0d want 000 0", {plot, busy, done}, rom_addr);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      if (plot || busy || done) bad++;
    end
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (plot || busy || done) bad++;
    end
    total++; if (bad !== 0) $display("FAIL midop_no_resume: got %0d active cycles want 0", bad); else passed++;
    run_op(1'b1, 1'b0, 8'd10, 7'd20, 400, 0, 1'b0);
    total++; if (n_plot !== 256 || addr_bad !== 0 || coord_bad !== 0)
      $display("FAIL midop_redraw: got %0d plots %0d addr_bad %0d bad want 256 0 0", n_plot, addr_bad, coord_bad);
    else passed++;
    total++; if (done_c !== 259) $display("FAIL midop_redraw_done: got %0d want 259", done_c); else passed++;
  endtask

  task automatic test_back_to_back;
    int n = -1;
    rom_mode = 0;
    run_op(1'b1, 1'b0, 8'd0, 7'd0, 400, 0, 1'b1);
    total++; if (done_c !== 259) $display("FAIL b2b_first_done: got %0d want 259", done_c); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_idle_gap: got busy %b done %b want 0 0", busy, done); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b1 || rom_addr !== 8'd0)
      $display("FAIL b2b_restart: got busy %b addr %0d want 1 0", busy, rom_addr); else passed++;
    start = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    total++; if (n !== 258) $display("FAIL b2b_second_done: got %0d cycles want 258", n); else passed++;
  endtask

  initial begin
    test_reset();
    test_draw();
    test_clip();
    test_key();
    test_clear();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter X_SCREEN_PIXELS, default 8'd160, horizontal screen size in pixels.
REQ-002 Parameter Y_SCREEN_PIXELS, default 7'd120, vertical screen size in pixels.
REQ-003 Parameter SPRITE_W, default 16, sprite width in pixels.
REQ-004 Parameter SPRITE_H, default 16, sprite height in pixels.
REQ-005 Parameter KEY_COLOUR, default 3'b101, transparent colour that is never plotted.
REQ-006 clk  in  1  single system clock; all state changes on the rising edge.
REQ-007 resetn  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  request to draw a sprite; accepted only in IDLE.
REQ-009 clear  in  1  request to fill the whole screen black; accepted only in IDLE.
REQ-010 x_in  in  8  sprite top-left x; sampled on the accepting edge.
REQ-011 y_in  in  7  sprite top-left y; sampled on the accepting edge.
REQ-012 rom_addr  out  8  sprite ROM address, row-major: row*SPRITE_W + col.
REQ-013 rom_data  in  3  synchronous ROM output for the rom_addr of the previous cycle.
REQ-014 x  out  8  pixel x to the VGA adapter.
REQ-015 y  out  7  pixel y to the VGA adapter.
REQ-016 colour  out  3  pixel colour to the VGA adapter.
REQ-017 plot  out  1  write enable to the VGA adapter; x/y/colour are valid when it is high.
REQ-018 busy  out  1  high while a draw or clear operation is in progress.
REQ-019 done  out  1  one-cycle pulse on completion of an operation.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DRAW, CLEAR, DONE; all outputs are registered.
REQ-021 In IDLE, clear high SHALL go to CLEAR; start high with clear low SHALL go to FETCH; clear wins when both are high.
REQ-022 start and clear SHALL be ignored in every state other than IDLE. No queuing.
REQ-023 On acceptance of start, x_in/y_in SHALL be latched, and rom_addr SHALL be 0 in the next cycle, then increment by 1 every cycle up to SPRITE_W*SPRITE_H-1.
REQ-024 Pixel k SHALL appear on x/y/colour two cycles after rom_addr==k.
- x = x_base + k mod SPRITE_W.
- y = y_base + k div SPRITE_W.
- colour = rom_data.
REQ-025 plot SHALL be high for pixel k only when all of the following hold: rom_data != KEY_COLOUR, 9-bit sum x < X_SCREEN_PIXELS, and 8-bit sum y < Y_SCREEN_PIXELS. Off-screen pixels are clipped, never wrapped.
REQ-026 With start accepted at the end of cycle 0:
- busy SHALL be high in cycles 1..SPRITE_W*SPRITE_H+2.
- The last pixel SHALL be output in cycle SPRITE_W*SPRITE_H+2.
- done SHALL be high in cycle SPRITE_W*SPRITE_H+3 only, with busy low and the FSM in DONE.
- The FSM SHALL return to IDLE the following cycle.
REQ-027 In CLEAR, the block SHALL output one pixel per cycle, starting the cycle after acceptance:
- colour 3'b000, plot high.
- x runs 0..X_SCREEN_PIXELS-1, then wraps to 0 with y+1.
- Sequence ends after (X_SCREEN_PIXELS-1, Y_SCREEN_PIXELS-1).
REQ-028 Clear timing SHALL match REQ-026, with X_SCREEN_PIXELS*Y_SCREEN_PIXELS pixels in cycles 1..19200 and done in cycle 19201 (defaults).
REQ-029 Outside DRAW/CLEAR pixel slots, plot SHALL be 0; x/y/colour hold their last values.
REQ-030 start or clear held high continuously SHALL produce one operation per IDLE visit, with at least one IDLE cycle between operations.

Reset
REQ-031 resetn low SHALL immediately, without a clock edge, force the following:
- state IDLE.
- rom_addr, x, y, colour = 0.
- plot, busy, done = 0.
REQ-032 Reset asserted mid-operation SHALL abort it with no further plot and no done pulse. Operation resumes only on a new start/clear after reset release.

Verification
REQ-033 Sprite at (10,20), ROM with all entries 3'b010 -> 256 plots in cycles 3..258 covering x 10..25, y 20..35; done in cycle 259 only.
REQ-034 Sprite at (150,110), all entries 3'b001 -> plots only for x 150..159, y 110..119 (100 plots); no wrapped coordinates; done in cycle 259.
REQ-035 ROM entry k = KEY_COLOUR for even k, 3'b100 for odd k, at (0,0) -> exactly 128 plots, all at odd x, colour 3'b100.
REQ-036 start and clear high together in IDLE -> clear sequence; first pixel (0,0) in cycle 1, last (159,119) in cycle 19200, done in cycle 19201; a start pulsed mid-clear is ignored.
REQ-037 resetn pulsed low at sprite pixel 40 -> plot/busy/done drop to 0 asynchronously, no done; a fresh start after release draws the full sprite from rom_addr 0.
